// File: rtl/rv_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rv_rr_arbiter
//
// Round-robin arbiter that merges NUM_PORTS ready/valid requesters onto one
// registered ready/valid output channel. A packet spans one or more beats,
// and its final beat has last=1. Once the first beat of a multi-beat packet
// is granted, the arbiter locks onto that port until the last beat passes.
// No other port can inject beats while the lock is held. The output side is
// a single-entry forward buffer. It sustains one beat per cycle, adds one
// cycle of latency, and drives the output registers with no combinational
// path to them.
//
// Handshake semantics (all channels):
//   A beat transfers on a rising clock edge where valid and ready are both
//   high. A source that raises valid keeps data/last stable until that edge.
//   Ready may depend combinationally on valid. Valid never depends on ready.
//
// Ports:
//   clock_port         in   clock, all state updates on the rising edge
//   reset_port         in   asynchronous active-high reset
//   input_port_data    in   packed payloads, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   input_port_last    in   per-port end-of-packet flag
//   input_port_valid   in   per-port valid
//   input_port_ready   out  per-port ready (at most one bit set)
//   output_port_data   out  registered payload
//   output_port_last   out  registered end-of-packet flag
//   output_port_id     out  index of the port that sourced the buffered beat
//   output_port_valid  out  registered valid
//   output_port_ready  in   downstream ready
//   dbg_locked_o       out  1 while a multi-beat packet holds the lock
//   dbg_rr_ptr_o       out  round-robin pointer (highest-priority port in IDLE)
//   dbg_lock_id_o      out  port that owns the lock (meaningful when locked)
// ---------------------------------------------------------------------------
module rv_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                            clock_port,
    input  logic                            reset_port,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] input_port_data,
    input  logic [NUM_PORTS-1:0]            input_port_last,
    input  logic [NUM_PORTS-1:0]            input_port_valid,
    output logic [NUM_PORTS-1:0]            input_port_ready,
    output logic [DATA_WIDTH-1:0]           output_port_data,
    output logic                            output_port_last,
    output logic [ID_WIDTH-1:0]             output_port_id,
    output logic                            output_port_valid,
    input  logic                            output_port_ready,
    output logic                            dbg_locked_o,
    output logic [ID_WIDTH-1:0]             dbg_rr_ptr_o,
    output logic [ID_WIDTH-1:0]             dbg_lock_id_o
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  state_q,     state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [ID_WIDTH-1:0]     lock_id_q,   lock_id_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [DATA_WIDTH-1:0]   buf_data_q,  buf_data_d;
    logic                    buf_last_q,  buf_last_d;
    logic [ID_WIDTH-1:0]     buf_id_q,    buf_id_d;

    // -----------------------------------------------------------------------
    // Selection
    // -----------------------------------------------------------------------
    logic                    accept;
    logic                    sel_found;
    logic [ID_WIDTH-1:0]     sel_idx;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;
    logic                    sel_valid;
    logic                    transfer;
    int                      cand;

    // The buffer can take a new beat when it is empty, or when its current
    // beat leaves this same cycle.
    assign accept = ~buf_valid_q | output_port_ready;

    // In IDLE the arbiter scans from rr_ptr upward and wraps at NUM_PORTS.
    // The first valid port it finds wins. In LOCKED the lock owner is
    // selected unconditionally, even while it is idle, so no other port can
    // slip a beat into the middle of the packet.
    always_comb begin : select_port
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        if (state_q == ST_LOCKED) begin
            sel_found = 1'b1;
            sel_idx   = lock_id_q;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= NUM_PORTS) begin
                    cand = cand - NUM_PORTS;
                end
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (!sel_found && (i == cand) && input_port_valid[i]) begin
                        sel_found = 1'b1;
                        sel_idx   = ID_WIDTH'(i);
                    end
                end
            end
        end
    end

    // Mux the selected port's beat onto the buffer-load path.
    always_comb begin : select_beat
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (int'(sel_idx) == i) begin
                sel_data  = input_port_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last  = input_port_last[i];
                sel_valid = input_port_valid[i];
            end
        end
    end

    // Only the selected port sees ready. In LOCKED the owner sees ready even
    // while its valid is low, which is legal because ready may lead valid.
    always_comb begin : drive_ready
        input_port_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            input_port_ready[i] = accept & sel_found & (int'(sel_idx) == i);
        end
    end

    assign transfer = accept & sel_found & sel_valid;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_id_d   = lock_id_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        buf_id_d    = buf_id_q;

        if (transfer) begin
            // A new beat overwrites the buffer. If the old beat drains in the
            // same cycle, valid stays high and the channel runs at full rate.
            buf_valid_d = 1'b1;
            buf_data_d  = sel_data;
            buf_last_d  = sel_last;
            buf_id_d    = sel_idx;
            if (sel_last) begin
                // End of packet: release the lock and give priority to the
                // port after the one just served.
                state_d = ST_IDLE;
                if (sel_idx == ID_WIDTH'(NUM_PORTS - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = sel_idx + 1'b1;
                end
            end else begin
                state_d   = ST_LOCKED;
                lock_id_d = sel_idx;
            end
        end else if (output_port_ready) begin
            // Drain only. The payload registers keep their last contents.
            buf_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_port or posedge reset_port) begin : regs
        if (reset_port) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            lock_id_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            buf_last_q  <= 1'b0;
            buf_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_id_q   <= lock_id_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            buf_id_q    <= buf_id_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign output_port_valid = buf_valid_q;
    assign output_port_data  = buf_data_q;
    assign output_port_last  = buf_last_q;
    assign output_port_id    = buf_id_q;

    assign dbg_locked_o  = (state_q == ST_LOCKED);
    assign dbg_rr_ptr_o  = rr_ptr_q;
    assign dbg_lock_id_o = lock_id_q;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv_rr_arbiter
//
// Each input port is fed from its own beat queue: valid is high whenever the
// queue holds a beat, and the beat is popped on handshake. A reference model
// tracks the arbitration state (locked owner, priority pointer) and predicts
// the grant and the ready vector. Every beat it predicts to be accepted goes
// into exp_q, and exp_q is compared against the DUT output every cycle.
// ---------------------------------------------------------------------------
module tb_rv_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int BW = IW + 1 + DW;   // {id, last, data}
    localparam int SD = 64;            // per-port source ring depth

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // DUT
    // -----------------------------------------------------------------------
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]    in_last;
    logic [NP-1:0]    in_valid;
    logic [NP-1:0]    in_ready;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic [IW-1:0]    out_id;
    logic             out_valid;
    logic             out_ready;
    logic             dbg_locked;
    logic [IW-1:0]    dbg_rr_ptr;
    logic [IW-1:0]    dbg_lock_id;

    rv_rr_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .clock_port        (clk),
        .reset_port        (rst),
        .input_port_data   (in_data),
        .input_port_last   (in_last),
        .input_port_valid  (in_valid),
        .input_port_ready  (in_ready),
        .output_port_data  (out_data),
        .output_port_last  (out_last),
        .output_port_id    (out_id),
        .output_port_valid (out_valid),
        .output_port_ready (out_ready),
        .dbg_locked_o      (dbg_locked),
        .dbg_rr_ptr_o      (dbg_rr_ptr),
        .dbg_lock_id_o     (dbg_lock_id)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    logic [BW-1:0] exp_q[$];

    logic [8:0] src_mem [NP][SD];   // {last, data}
    int         src_rd  [NP];
    int         src_wr  [NP];

    bit m_locked;
    int m_lock;
    int m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int src_count(input int p);
        return src_wr[p] - src_rd[p];
    endfunction

    task automatic push_beat(input int p, input logic [7:0] d, input logic l);
        src_mem[p][src_wr[p] % SD] = {l, d};
        src_wr[p]++;
    endtask

    task automatic clear_sources();
        for (int p = 0; p < NP; p++) begin
            src_rd[p] = 0;
            src_wr[p] = 0;
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_lock   = 0;
        m_ptr    = 0;
        exp_q.delete();
    endtask

    // -----------------------------------------------------------------------
    // Driver: present the head of each source queue
    // -----------------------------------------------------------------------
    task automatic drive_inputs();
        logic [8:0] b;
        for (int p = 0; p < NP; p++) begin
            if (src_count(p) > 0) begin
                b = src_mem[p][src_rd[p] % SD];
                in_valid[p]          = 1'b1;
                in_last[p]           = b[8];
                in_data[p*DW +: DW]  = b[7:0];
            end else begin
                in_valid[p]          = 1'b0;
                in_last[p]           = 1'b0;
                in_data[p*DW +: DW]  = '0;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model, evaluated mid-cycle with inputs stable
    // -----------------------------------------------------------------------
    task automatic model_cycle();
        bit            can_take;
        int            w;
        logic [NP-1:0] exp_ready;
        logic [8:0]    b;
        logic [IW-1:0] wid;

        // The buffer holds exactly the beats accepted but not yet delivered.
        can_take = (exp_q.size() == 0) || out_ready;

        check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_eq("out_beat", 32'({out_id, out_last, out_data}), 32'(exp_q[0]));
        end
        check_eq("locked", 32'(dbg_locked), 32'(m_locked));
        check_eq("rr_ptr", 32'(dbg_rr_ptr), 32'(m_ptr));
        if (m_locked) begin
            check_eq("lock_id", 32'(dbg_lock_id), 32'(m_lock));
        end

        // Grant: the lock owner if locked, else the first valid port found
        // by walking from the pointer with wraparound.
        w = -1;
        if (m_locked) begin
            w = m_lock;
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (w < 0 && in_valid[(m_ptr + k) % NP]) begin
                    w = (m_ptr + k) % NP;
                end
            end
        end

        exp_ready = '0;
        if (can_take && w >= 0) begin
            exp_ready[w] = 1'b1;
        end
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));

        // Effects of the coming edge.
        if (exp_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
        end
        if (w >= 0 && exp_ready[w] && in_valid[w]) begin
            b   = src_mem[w][src_rd[w] % SD];
            wid = IW'(w);
            exp_q.push_back({wid, b});
            src_rd[w]++;
            if (b[8]) begin
                m_locked = 1'b0;
                m_ptr    = (w + 1) % NP;
            end else begin
                m_locked = 1'b1;
                m_lock   = w;
            end
        end
    endtask

    // One cycle: drive at posedge+1, check at negedge, end at next posedge+1.
    task automatic step();
        drive_inputs();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        model_reset();
        out_ready = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_id", 32'(out_id), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_locked", 32'(dbg_locked), 32'd0);
        check_eq("rst_ptr", 32'(dbg_rr_ptr), 32'd0);
        rst = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int total;
        rst       = 1'b1;
        in_data   = '0;
        in_last   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        clear_sources();
        model_reset();

        // Reset, then idle with no requesters.
        do_reset();
        run(3);

        // Fair rotation: every port continuously valid with single-beat packets.
        for (int n = 0; n < 6; n++) begin
            for (int p = 0; p < NP; p++) begin
                push_beat(p, 8'(8'h10 + p), 1'b1);
            end
        end
        run(30);

        // Packet lock: port 2 locks first, then ports 0 and 3 request.
        // After the packet ends, port 3 must win before port 0.
        do_reset();
        push_beat(2, 8'hA0, 1'b0);
        push_beat(2, 8'hA1, 1'b0);
        push_beat(2, 8'hA2, 1'b1);
        step();
        push_beat(0, 8'h01, 1'b1);
        push_beat(3, 8'h03, 1'b1);
        run(10);

        // Backpressure: one beat buffered while the output is stalled.
        do_reset();
        out_ready = 1'b0;
        push_beat(1, 8'h5A, 1'b1);
        step();
        push_beat(2, 8'h66, 1'b1);
        run(3);
        check_eq("bp_hold_data", 32'(out_data), 32'h5A);
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        run(4);

        // Wrap-around: pointer parked at 3, then ports 1 and 3 request.
        do_reset();
        push_beat(2, 8'h22, 1'b1);
        step();
        push_beat(1, 8'h11, 1'b1);
        push_beat(3, 8'h33, 1'b1);
        run(5);

        // Reset asserted asynchronously mid-packet while port 1 is locked.
        do_reset();
        push_beat(1, 8'hB0, 1'b0);
        push_beat(1, 8'hB1, 1'b0);
        push_beat(1, 8'hB2, 1'b0);
        run(2);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_valid", 32'(out_valid), 32'd0);
        check_eq("async_locked", 32'(dbg_locked), 32'd0);
        check_eq("async_ptr", 32'(dbg_rr_ptr), 32'd0);
        do_reset();
        push_beat(1, 8'hC1, 1'b1);
        push_beat(0, 8'hC0, 1'b1);
        run(4);

        // Randomized traffic with random packet lengths and output stalls.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (src_count(p) < 6 && $urandom_range(0, 2) == 0) begin
                    push_beat(p, 8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0));
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Close every open packet, then drain with a bounded cycle budget.
        for (int p = 0; p < NP; p++) begin
            push_beat(p, 8'hEE, 1'b1);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            total = 0;
            for (int p = 0; p < NP; p++) begin
                total += src_count(p);
            end
            if (total == 0 && exp_q.size() == 0) begin
                break;
            end
            step();
        end
        total = 0;
        for (int p = 0; p < NP; p++) begin
            total += src_count(p);
        end
        check_eq("drain_src", 32'(total), 32'd0);
        check_eq("drain_buf", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
